io_wait_controller: RTL and testbench
=====================================

IO_WAIT_CONTROLLER -- requirements
Module: io_wait_controller

Interface
REQ-001 Parameter WAIT_MIN, default 2: minimum ACCESS cycles per transfer; legal range 1..255.
REQ-002 Parameter TIMEOUT, default 255: ACCESS cycles before abort; legal range WAIT_MIN+1..255.
REQ-003 clock  input  1  single system clock; all state updates on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 ioread  input  1  CPU IO read request, level, held while cpu_stall=1.
REQ-006 iowrite  input  1  CPU IO write request, level, held while cpu_stall=1.
REQ-007 address  input  32  CPU byte address of IO access.
REQ-008 wdata  input  32  CPU write data.
REQ-009 dev_rdata  input  16  read data from selected peripheral.
REQ-010 dev_ready  input  1  peripheral ready, sampled only in ACCESS.
REQ-011 err_clr  input  1  synchronous clear of timeout_err.
REQ-012 cpu_stall  output  1  freezes CPU pipeline.
REQ-013 io_addr  output  32  latched transfer address.
REQ-014 io_wdata  output  32  latched write data.
REQ-015 io_rd / io_wr  output  1 each  peripheral read/write strobes.
REQ-016 rdata  output  32  {16'h0000, captured read data}.
REQ-017 busy  output  1  high in every state except IDLE.
REQ-018 addr_err  output  1  one-cycle pulse on out-of-range request.
REQ-019 timeout_err  output  1  sticky abort flag.

Function
REQ-020 States: IDLE, SETUP, ACCESS, DONE; 8-bit cycle counter cnt.
REQ-021 Valid IO window: address[31:10] == 22'h3FFFFF (0xFFFFFC00..0xFFFFFFFF).
REQ-022 IDLE with (ioread|iowrite) and address in window: cpu_stall=1 combinationally in that cycle; latch address, wdata, direction; next state SETUP.
REQ-023 ioread and iowrite both high: transfer is a write.
REQ-024 IDLE with request and address outside window: no stall, no state change, addr_err=1 for that cycle only.
REQ-025 SETUP: one cycle; io_addr/io_wdata valid; io_rd=io_wr=0; cpu_stall=1; cnt<=0; next ACCESS.
REQ-026 ACCESS: io_rd (read) or io_wr (write) high; cpu_stall=1; cnt increments each cycle.
REQ-027 ACCESS exit (normal): cnt >= WAIT_MIN-1 and dev_ready=1 -> DONE; on a read, dev_rdata captured into rdata[15:0] at that edge.
REQ-028 ACCESS exit (abort): cnt == TIMEOUT-1 without normal exit -> DONE; timeout_err<=1; on a read, rdata<=32'h0.
REQ-029 Normal exit and abort in same cycle: normal exit wins; no error.
REQ-030 DONE: one cycle; cpu_stall=0, strobes low; next IDLE; requests sampled in DONE ignored.
REQ-031 Minimum transfer latency: WAIT_MIN+2 stall cycles; DONE at cycle WAIT_MIN+2 after request.
REQ-032 rdata holds until next read completes; writes never change rdata.
REQ-033 timeout_err: set by abort, cleared by err_clr; set and clear in same cycle -> set wins.
REQ-034 io_addr/io_wdata hold latched values until next accepted request.
REQ-035 Input changes during SETUP/ACCESS/DONE do not affect the transfer in progress.

Reset
REQ-036 reset_n=0 asynchronously forces IDLE, cnt=0, cpu_stall=0, io_rd=io_wr=0, io_addr=0, io_wdata=0, rdata=0, busy=0, addr_err=0, timeout_err=0.
REQ-037 Reset mid-transfer aborts immediately; strobes drop without passing through DONE; no error flag.

Verification
REQ-038 Read 0xFFFFFC70, dev_ready=1, dev_rdata=16'hA5A5, defaults -> cpu_stall high 4 cycles, io_rd high 2 cycles, rdata=32'h0000A5A5.
REQ-039 Write 0xFFFFFC60, wdata=32'h1234, dev_ready delayed to ACCESS cycle 5 -> io_wr high 6 cycles, io_wdata=32'h1234, no error.
REQ-040 Read with dev_ready=0 always -> DONE after 255 ACCESS cycles, timeout_err=1, rdata=0; err_clr pulse -> timeout_err=0.
REQ-041 Request to 0x00000010 with iowrite=1 -> addr_err one-cycle pulse, cpu_stall=0, state stays IDLE.
REQ-042 reset_n low during ACCESS -> cpu_stall, io_rd, busy low immediately; next request transfers normally.
REQ-043 ioread=iowrite=1 to 0xFFFFFC00 -> io_wr asserted, io_rd never asserted.

Source files
------------

// File: rtl/io_wait_controller.sv
// Stalls the CPU while an IO read/write runs IDLE->SETUP->ACCESS->DONE against a slow peripheral.
// Latency: WAIT_MIN+2 stall cycles minimum; dev_ready extends ACCESS, and the access aborts after TIMEOUT cycles.
module io_wait_controller #(
    parameter int unsigned WAIT_MIN = 2,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        ioread,
    input  logic        iowrite,
    input  logic [31:0] address,
    input  logic [31:0] wdata,
    input  logic [15:0] dev_rdata,
    input  logic        dev_ready,
    input  logic        err_clr,
    output logic        cpu_stall,
    output logic [31:0] io_addr,
    output logic [31:0] io_wdata,
    output logic        io_rd,
    output logic        io_wr,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        addr_err,
    output logic        timeout_err
);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_DONE} state_t;

    localparam logic [7:0] C_EXIT_MIN = 8'(WAIT_MIN - 1);
    localparam logic [7:0] C_TO_LAST  = 8'(TIMEOUT - 1);

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_cnt;
    logic        r_is_wr;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [15:0] r_rdata;
    logic        r_timeout_err;

    logic        w_req;
    logic        w_in_window;
    logic        w_accept;
    logic        w_addr_bad;
    logic        w_ready_exit;
    logic        w_abort;

    assign w_req        = ioread | iowrite;
    assign w_in_window  = (address[31:10] == 22'h3FFFFF);
    // Gated by reset_n so the combinational request outputs stay low while reset is held.
    assign w_accept     = reset_n && (r_state == S_IDLE) && w_req && w_in_window;
    assign w_addr_bad   = reset_n && (r_state == S_IDLE) && w_req && !w_in_window;
    assign w_ready_exit = (r_state == S_ACCESS) && (r_cnt >= C_EXIT_MIN) && dev_ready;
    assign w_abort      = (r_state == S_ACCESS) && (r_cnt == C_TO_LAST) && !w_ready_exit;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_accept) w_next = S_SETUP;
            S_SETUP:  w_next = S_ACCESS;
            S_ACCESS: if (w_ready_exit || w_abort) w_next = S_DONE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        cpu_stall = 1'b0;
        io_rd     = 1'b0;
        io_wr     = 1'b0;
        busy      = 1'b0;
        addr_err  = 1'b0;
        case (r_state)
            S_IDLE: begin
                cpu_stall = w_accept;
                addr_err  = w_addr_bad;
            end
            S_SETUP: begin
                cpu_stall = 1'b1;
                busy      = 1'b1;
            end
            S_ACCESS: begin
                cpu_stall = 1'b1;
                busy      = 1'b1;
                io_rd     = !r_is_wr;
                io_wr     = r_is_wr;
            end
            S_DONE: begin
                busy      = 1'b1;
            end
            default: begin
                busy      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt         <= 8'd0;
            r_is_wr       <= 1'b0;
            r_addr        <= 32'd0;
            r_wdata       <= 32'd0;
            r_rdata       <= 16'd0;
            r_timeout_err <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr  <= address;
                r_wdata <= wdata;
                r_is_wr <= iowrite;
            end

            if (r_state == S_SETUP) begin
                r_cnt <= 8'd0;
            end else if (r_state == S_ACCESS) begin
                r_cnt <= r_cnt + 8'd1;
            end

            if (w_ready_exit && !r_is_wr) begin
                r_rdata <= dev_rdata;
            end else if (w_abort && !r_is_wr) begin
                r_rdata <= 16'd0;
            end

            // An abort in the same cycle as err_clr leaves the flag set.
            if (w_abort) begin
                r_timeout_err <= 1'b1;
            end else if (err_clr) begin
                r_timeout_err <= 1'b0;
            end
        end
    end

    assign io_addr     = r_addr;
    assign io_wdata    = r_wdata;
    assign rdata       = {16'h0000, r_rdata};
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_io_wait_controller.sv
// Bench for io_wait_controller: directed table, reset/addr-error sequences, then random transfers vs a reference model.
module tb_io_wait_controller;

    localparam int WMIN = 2;
    localparam int TMO  = 255;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        ioread, iowrite;
    logic [31:0] address, wdata;
    logic [15:0] dev_rdata;
    logic        dev_ready, err_clr;
    logic        cpu_stall, io_rd, io_wr, busy, addr_err, timeout_err;
    logic [31:0] io_addr, io_wdata, rdata;

    int n_checks = 0;
    int n_err    = 0;

    logic [31:0] exp_rdata = 32'd0;
    logic        exp_terr  = 1'b0;
    logic [31:0] last_addr = 32'd0;
    logic [31:0] last_wd   = 32'd0;

    io_wait_controller #(.WAIT_MIN(WMIN), .TIMEOUT(TMO)) dut (
        .clock(clock), .reset_n(reset_n), .ioread(ioread), .iowrite(iowrite),
        .address(address), .wdata(wdata), .dev_rdata(dev_rdata), .dev_ready(dev_ready),
        .err_clr(err_clr), .cpu_stall(cpu_stall), .io_addr(io_addr), .io_wdata(io_wdata),
        .io_rd(io_rd), .io_wr(io_wr), .rdata(rdata), .busy(busy), .addr_err(addr_err),
        .timeout_err(timeout_err)
    );

    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not end, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [15:0] drd;
        int          rdy_at;   // first ACCESS index with dev_ready high, -1 = never
        bit          clr;      // hold err_clr high until the exit edge
        int          exp_n;    // expected ACCESS cycles
        bit          exp_to;
    } vec_t;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: the transfer leaves ACCESS at the first cycle i >= WAIT_MIN-1 with ready,
    // otherwise after TIMEOUT cycles with an error.
    function automatic void ref_exit(input logic [255:0] rb, output int n, output bit to);
        n  = TMO;
        to = 1'b1;
        for (int i = 0; i < TMO; i++) begin
            if (i >= WMIN - 1 && rb[i]) begin
                n  = i + 1;
                to = 1'b0;
                break;
            end
        end
    endfunction

    task automatic run_txn(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                           input logic [15:0] drd, input logic [255:0] rb, input int exp_n,
                           input bit exp_to, input bit hold_clr, input string tag);
        logic [31:0] new_rdata;
        logic        new_terr;
        new_rdata = wr ? exp_rdata : (exp_to ? 32'd0 : {16'h0000, drd});
        new_terr  = exp_to ? 1'b1 : (hold_clr ? 1'b0 : exp_terr);
        for (int c = 0; c <= exp_n + 3; c++) begin
            @(negedge clock);
            if (c == 0) begin
                ioread = rd; iowrite = wr; address = a; wdata = wd;
            end else if (c < exp_n + 2) begin
                address = $urandom; wdata = $urandom;
            end else if (c == exp_n + 2) begin
                address = a; wdata = $urandom;   // request still asserted in DONE
            end else begin
                ioread = 1'b0; iowrite = 1'b0; address = $urandom;
            end
            dev_ready = (c >= 2 && c <= exp_n + 1) ? rb[c-2] : 1'($urandom);
            dev_rdata = (c == exp_n + 1) ? drd : 16'($urandom);
            err_clr   = hold_clr && (c <= exp_n + 1);
            #1;
            check($sformatf("%s stall c%0d", tag, c), 32'(cpu_stall), 32'(c <= exp_n + 1));
            check($sformatf("%s busy c%0d", tag, c), 32'(busy), 32'(c >= 1 && c <= exp_n + 2));
            check($sformatf("%s io_rd c%0d", tag, c), 32'(io_rd), 32'(!wr && c >= 2 && c <= exp_n + 1));
            check($sformatf("%s io_wr c%0d", tag, c), 32'(io_wr), 32'(wr && c >= 2 && c <= exp_n + 1));
            if (c == 1 || c == exp_n + 3) begin
                check($sformatf("%s io_addr c%0d", tag, c), io_addr, a);
                check($sformatf("%s io_wdata c%0d", tag, c), io_wdata, wd);
                check($sformatf("%s addr_err c%0d", tag, c), 32'(addr_err), 32'd0);
            end
            if (c == exp_n + 2 || c == exp_n + 3) begin
                check($sformatf("%s rdata c%0d", tag, c), rdata, new_rdata);
                check($sformatf("%s timeout_err c%0d", tag, c), 32'(timeout_err), 32'(new_terr));
            end
        end
        exp_rdata = new_rdata;
        exp_terr  = new_terr;
        last_addr = a;
        last_wd   = wd;
        err_clr   = 1'b0;
    endtask

    task automatic bad_addr(input logic [31:0] a, input logic rd, input logic wr, input string tag);
        @(negedge clock);
        ioread = rd; iowrite = wr; address = a;
        #1;
        check({tag, " addr_err pulse"}, 32'(addr_err), 32'd1);
        check({tag, " no stall"}, 32'(cpu_stall), 32'd0);
        @(negedge clock);
        ioread = 1'b0; iowrite = 1'b0;
        #1;
        check({tag, " addr_err drop"}, 32'(addr_err), 32'd0);
        check({tag, " stays idle"}, 32'(busy), 32'd0);
        check({tag, " io_addr held"}, io_addr, last_addr);
    endtask

    vec_t tbl [8];

    initial begin
        logic [255:0] rb;
        int           n;
        bit           to;
        logic         rd, wr;
        logic [31:0]  a;

        tbl[0] = '{1'b1, 1'b0, 32'hFFFFFC70, 32'h0,        16'hA5A5,  0, 1'b0,   2, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 32'hFFFFFC60, 32'h1234,     16'h0000,  5, 1'b0,   6, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 32'hFFFFFC10, 32'h0,        16'hBEEF, -1, 1'b0, 255, 1'b1};
        tbl[3] = '{1'b1, 1'b1, 32'hFFFFFC00, 32'hCAFEF00D, 16'h1111,  0, 1'b0,   2, 1'b0};
        tbl[4] = '{1'b1, 1'b0, 32'hFFFFFFFF, 32'h0,        16'h5A5A,  1, 1'b1,   2, 1'b0};
        tbl[5] = '{1'b1, 1'b0, 32'hFFFFFC20, 32'h0,        16'h7777, 254, 1'b0, 255, 1'b0};
        tbl[6] = '{1'b1, 1'b0, 32'hFFFFFC30, 32'h0,        16'h1357, -1, 1'b1, 255, 1'b1};
        tbl[7] = '{1'b0, 1'b1, 32'hFFFFFC34, 32'h9,        16'h0000,  2, 1'b0,   3, 1'b0};

        reset_n = 1'b0; ioread = 1'b1; iowrite = 1'b0; address = 32'hFFFFFC00;
        wdata = 32'h0; dev_rdata = 16'h0; dev_ready = 1'b1; err_clr = 1'b0;
        #12;
        check("reset stall", 32'(cpu_stall), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset strobes", 32'({io_rd, io_wr}), 32'd0);
        check("reset addr_err", 32'(addr_err), 32'd0);
        check("reset io_addr", io_addr, 32'd0);
        check("reset io_wdata", io_wdata, 32'd0);
        check("reset rdata", rdata, 32'd0);
        check("reset timeout_err", 32'(timeout_err), 32'd0);
        @(negedge clock);
        reset_n = 1'b1; ioread = 1'b0;

        for (int i = 0; i < 8; i++) begin
            rb = '1;
            if (tbl[i].rdy_at < 0) rb = '0;
            else rb = rb << tbl[i].rdy_at;
            run_txn(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wd, tbl[i].drd, rb,
                    tbl[i].exp_n, tbl[i].exp_to, tbl[i].clr, $sformatf("vec%0d", i));
        end

        @(negedge clock);
        err_clr = 1'b1;
        @(negedge clock);
        err_clr = 1'b0;
        #1;
        check("err_clr clears", 32'(timeout_err), 32'd0);
        exp_terr = 1'b0;

        bad_addr(32'h00000010, 1'b0, 1'b1, "bad low");
        bad_addr(32'hFFFFFBFF, 1'b1, 1'b0, "bad edge");

        // Reset in the middle of ACCESS.
        @(negedge clock);
        ioread = 1'b1; iowrite = 1'b0; address = 32'hFFFFFC40; dev_ready = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        check("mid io_rd before reset", 32'(io_rd), 32'd1);
        reset_n = 1'b0;
        #1;
        check("mid reset stall", 32'(cpu_stall), 32'd0);
        check("mid reset io_rd", 32'(io_rd), 32'd0);
        check("mid reset busy", 32'(busy), 32'd0);
        check("mid reset timeout_err", 32'(timeout_err), 32'd0);
        check("mid reset io_addr", io_addr, 32'd0);
        @(negedge clock);
        reset_n = 1'b1; ioread = 1'b0;
        exp_rdata = 32'd0; exp_terr = 1'b0;
        run_txn(1'b1, 1'b0, 32'hFFFFFC44, 32'h0, 16'h4242, '1, 2, 1'b0, 1'b0, "post reset");

        for (int t = 0; t < 60; t++) begin
            if ($urandom_range(0, 5) == 0) begin
                a = $urandom;
                a[20] = 1'b0;
                bad_addr(a, 1'($urandom), 1'b1, $sformatf("rnd%0d bad", t));
            end
            case ($urandom_range(0, 2))
                0:       begin rd = 1'b1; wr = 1'b0; end
                1:       begin rd = 1'b0; wr = 1'b1; end
                default: begin rd = 1'b1; wr = 1'b1; end
            endcase
            a = {22'h3FFFFF, 10'($urandom)};
            rb = '0;
            if ($urandom_range(0, 7) != 0) begin
                for (int i = 0; i < 256; i++) rb[i] = ($urandom_range(0, 3) == 0);
            end
            ref_exit(rb, n, to);
            run_txn(rd, wr, a, $urandom, 16'($urandom), rb, n, to, ($urandom_range(0, 3) == 0),
                    $sformatf("rnd%0d", t));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
